ps2_kbd_decoder: RTL and testbench
==================================

# ps2_kbd_decoder

Receives the emulated PS/2 keyboard stream (`ps2_kbd_clk`/`ps2_kbd_data`) produced by the MiST I/O controller and turns it into discrete key events. It deserialises and checks 11-bit frames, resolves the E0/F0/E1 prefixes and queues `{ext, release, code}` events in a small FIFO with a valid/ready handshake. It sits between the I/O controller and the core's keyboard-to-joystick / coin / start mapping logic.

## Interface
- `FILT`, default 4: consecutive identical synchronised samples needed to accept a new PS/2 clock level.
- `TIMEOUT`, default 4096: `clk_sys` cycles without a falling edge that abort a partial frame.
- `FIFO_DEPTH`, default 4: event FIFO entries; must be a power of 2 and ≥2.

Ports:
- `clk_sys`  in  1  system clock; every flop is on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `ps2_clk`  in  1  PS/2 clock from the I/O controller; asynchronous to the block.
- `ps2_data`  in  1  PS/2 data from the I/O controller; asynchronous to the block.
- `key_valid`  out  1  FIFO head holds an event.
- `key_ready`  in  1  consumer accepts the head event when `key_valid` is also high.
- `key_code`  out  8  scan code of the head event.
- `key_ext`  out  1  event was preceded by E0 (or is the Pause event).
- `key_release`  out  1  event was preceded by F0.
- `overflow`  out  1  sticky; an event was dropped because the FIFO was full.
- `err_cnt`  out  8  count of dropped frames (parity, start or stop error, timeout); saturates at 255.

## Operation
- Input conditioning: 2-flop synchroniser on each input, then a `FILT`-sample glitch filter on the clock. A filtered 1→0 transition is a "fall". Data is sampled from the synchronised `ps2_data` on the fall.
- Frame states:
  - IDLE: on a fall, data=0 → DATA with bit count 0; data=1 → count an error and stay in IDLE.
  - DATA: 8 bits, LSB first.
  - PARITY: odd parity; total ones over data and parity must be odd.
  - STOP: must be 1. When parity and stop are good, emit the byte; otherwise count an error. Either way → IDLE.
- Timeout: in any state except IDLE, `TIMEOUT` cycles without a fall → IDLE, count an error, clear prefix flags.
- Byte decoder:
  - E0 sets `ext`.
  - F0 sets `rel`.
  - E1 enters the pause-skip state: the next 7 bytes are discarded, then one event {ext=1, rel=0, code=8'h77} is pushed.
  - 00, AA, EE, FA, FE, FF: discarded; flags cleared.
  - Any other byte: push {ext, rel, byte}; clear both flags.
  - A frame error also clears `ext`, `rel` and pause-skip.
- FIFO:
  - Push when an event is produced and the FIFO is not full.
  - Push while full: drop the event and set `overflow`.
  - Pop when `key_valid && key_ready`.
  - Push and pop in the same cycle while full: the pop frees a slot and the push is accepted; `overflow` is not set.
  - Pointers wrap modulo `FIFO_DEPTH`; occupancy counter is log2(`FIFO_DEPTH`)+1 bits.
- `err_cnt` increments by 1 per dropped frame and holds at 255.

## Timing
- Reset values:
  - `key_valid`=0, `key_code`=0, `key_ext`=0, `key_release`=0, `overflow`=0, `err_cnt`=0.
  - FIFO empty; frame FSM in IDLE; prefix flags 0.
  - Synchroniser and filter flops preset to 1 (idle bus).
- Fall detect latency: 2 (synchroniser) + `FILT` cycles after the raw `ps2_clk` edge.
- Stop-bit fall at cycle N: byte is available to the decoder at N+1; event is written to the FIFO at N+2; `key_valid` is high at N+2 when the FIFO was empty.
- FIFO outputs are registered head data; they are stable while `key_valid && !key_ready`.
- Reset mid-frame abandons the frame immediately. A frame whose start bit was missed by reset is rejected on start or parity/stop and counted in `err_cnt`.

## Structure
- Package `ps2_pkg` holds:
  - Frame state enum: IDLE, DATA, PARITY, STOP.
  - Decoder state enum: NORM, SKIP.
  - Constants `PS2_EXT`=8'hE0, `PS2_REL`=8'hF0, `PS2_PAUSE`=8'hE1, and the discard-code list.
- Sub-module `ps2_rx_frame` holds the synchroniser, filter, frame FSM and timeout. It outputs `byte_valid`, `byte_data` and `frame_err`.
- Prefix decoder and FIFO live in the top level.

## Test plan
- Send frame 0x1C (odd parity OK) → one event {ext=0, rel=0, code=1C}; `err_cnt`=0.
- Send E0 F0 75 → one event {ext=1, rel=1, code=75}; no event for the prefixes.
- Send 0x29 with bad parity, then 0x29 good → `err_cnt`=1 and exactly one event, code=29.
- Stop toggling `ps2_clk` after 4 data bits for `TIMEOUT`+10 cycles, then send 0x16 → `err_cnt`=1; event code=16.
- Hold `key_ready`=0 and send 5 keys (`FIFO_DEPTH`=4) → first 4 retained in order and `overflow`=1; then draining returns the 4 in order.
- Send E1 14 77 E1 F0 14 F0 77 → exactly one event {ext=1, rel=0, code=77}.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard decoder.
package ps2_pkg;

  // Frame receiver states: waiting for start bit, shifting data, parity, stop.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_e;

  // Prefix decoder states: normal decoding or swallowing the Pause sequence.
  typedef enum logic {
    NORM = 1'b0,
    SKIP = 1'b1
  } dec_state_e;

  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_REL        = 8'hF0;
  localparam logic [7:0] PS2_PAUSE      = 8'hE1;
  localparam logic [7:0] PS2_PAUSE_CODE = 8'h77;
  // Bytes following E1 that belong to the Pause make sequence.
  localparam int         PAUSE_SKIP     = 7;

  // One queued key event.
  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } key_event_t;

  // Controller / self-test responses that never describe a key.
  function automatic logic is_discard(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronises and filters the bus, deserialises
// 11-bit frames and reports good bytes or frame errors as one-cycle pulses.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILT    = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic         clk_sys,
  input  logic         reset,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  output logic         byte_valid,
  output logic [7:0]   byte_data,
  output logic         frame_err,
  output frame_state_e state
);

  localparam int FW = $clog2(FILT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_clk_filt;
  logic [FW-1:0] r_filt_cnt;
  logic          w_fall;

  frame_state_e  r_state, w_state_nxt;
  logic [2:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_par, w_par_nxt;
  logic [TW-1:0] r_to_cnt, w_to_cnt_nxt;
  logic          w_byte_valid, w_err;
  logic          r_byte_valid, r_frame_err;
  logic [7:0]    r_byte_data;

  // The filter accepts a new clock level after FILT consecutive differing
  // samples; the fall is flagged in the same cycle the low level is accepted.
  assign w_fall = r_clk_filt && !r_clk_s2 && (r_filt_cnt == FW'(FILT - 1));

  // Two-flop synchronisers and clock glitch filter, preset to the idle bus.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_clk_filt <= 1'b1;
      r_filt_cnt <= '0;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
      if (r_clk_s2 == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FW'(FILT - 1)) begin
        r_clk_filt <= r_clk_s2;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + FW'(1);
      end
    end
  end

  // Frame FSM next state, shift/parity datapath and timeout watchdog.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_par_nxt     = r_par;
    w_to_cnt_nxt  = r_to_cnt;
    w_byte_valid  = 1'b0;
    w_err         = 1'b0;
    case (r_state)
      IDLE: begin
        w_to_cnt_nxt = '0;
        if (w_fall) begin
          if (!r_dat_s2) begin
            w_state_nxt   = DATA;
            w_bit_cnt_nxt = '0;
            w_par_nxt     = 1'b0;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      DATA: begin
        if (w_fall) begin
          w_shift_nxt   = {r_dat_s2, r_shift[7:1]};
          w_par_nxt     = r_par ^ r_dat_s2;
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
        end
      end
      PARITY: begin
        if (w_fall) begin
          w_par_nxt   = r_par ^ r_dat_s2;
          w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (w_fall) begin
          if (r_par && r_dat_s2) w_byte_valid = 1'b1;
          else                   w_err        = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // A stalled partial frame is abandoned and counted as an error.
    if (r_state != IDLE) begin
      if (w_fall) begin
        w_to_cnt_nxt = '0;
      end else if (r_to_cnt == TW'(TIMEOUT - 1)) begin
        w_state_nxt  = IDLE;
        w_to_cnt_nxt = '0;
        w_err        = 1'b1;
      end else begin
        w_to_cnt_nxt = r_to_cnt + TW'(1);
      end
    end
  end

  // Frame FSM state register and registered byte/error pulses.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_to_cnt     <= '0;
      r_byte_valid <= 1'b0;
      r_byte_data  <= '0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_par        <= w_par_nxt;
      r_to_cnt     <= w_to_cnt_nxt;
      r_byte_valid <= w_byte_valid;
      r_frame_err  <= w_err;
      if (w_byte_valid) r_byte_data <= r_shift;
    end
  end

  assign byte_valid = r_byte_valid;
  assign byte_data  = r_byte_data;
  assign frame_err  = r_frame_err;
  assign state      = r_state;

endmodule

// File: rtl/ps2_kbd_decoder.sv
// PS/2 keyboard decoder: frame receiver, E0/F0/E1 prefix decoding and a
// small event FIFO. Handshake: the head event transfers on any cycle where
// key_valid && key_ready; head outputs hold while key_valid && !key_ready.
module ps2_kbd_decoder
  import ps2_pkg::*;
#(
  parameter int FILT       = 4,
  parameter int TIMEOUT    = 4096,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk_sys,
  input  logic         reset,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  output logic         key_valid,
  input  logic         key_ready,
  output logic [7:0]   key_code,
  output logic         key_ext,
  output logic         key_release,
  output logic         overflow,
  output logic [7:0]   err_cnt,
  output frame_state_e dbg_frame_state,
  output dec_state_e   dbg_dec_state
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  logic       w_byte_valid, w_frame_err;
  logic [7:0] w_byte_data;

  ps2_rx_frame #(.FILT(FILT), .TIMEOUT(TIMEOUT)) u_rx (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_valid (w_byte_valid),
    .byte_data  (w_byte_data),
    .frame_err  (w_frame_err),
    .state      (dbg_frame_state)
  );

  dec_state_e r_dec_state, w_dec_state_nxt;
  logic       r_ext, w_ext_nxt, r_rel, w_rel_nxt;
  logic [2:0] r_skip_cnt, w_skip_cnt_nxt;
  logic       w_ev_valid;
  key_event_t w_ev;

  // Prefix decoder: tracks E0/F0 flags and the Pause skip, emits events.
  always_comb begin
    w_dec_state_nxt = r_dec_state;
    w_ext_nxt       = r_ext;
    w_rel_nxt       = r_rel;
    w_skip_cnt_nxt  = r_skip_cnt;
    w_ev_valid      = 1'b0;
    w_ev            = '0;
    if (w_frame_err) begin
      w_dec_state_nxt = NORM;
      w_ext_nxt       = 1'b0;
      w_rel_nxt       = 1'b0;
      w_skip_cnt_nxt  = '0;
    end else if (w_byte_valid) begin
      case (r_dec_state)
        NORM: begin
          if (w_byte_data == PS2_EXT) begin
            w_ext_nxt = 1'b1;
          end else if (w_byte_data == PS2_REL) begin
            w_rel_nxt = 1'b1;
          end else if (w_byte_data == PS2_PAUSE) begin
            w_dec_state_nxt = SKIP;
            w_skip_cnt_nxt  = 3'(PAUSE_SKIP);
            w_ext_nxt       = 1'b0;
            w_rel_nxt       = 1'b0;
          end else if (is_discard(w_byte_data)) begin
            w_ext_nxt = 1'b0;
            w_rel_nxt = 1'b0;
          end else begin
            w_ev_valid = 1'b1;
            w_ev       = '{ext: r_ext, rel: r_rel, code: w_byte_data};
            w_ext_nxt  = 1'b0;
            w_rel_nxt  = 1'b0;
          end
        end
        SKIP: begin
          w_skip_cnt_nxt = r_skip_cnt - 3'd1;
          if (r_skip_cnt == 3'd1) begin
            w_dec_state_nxt = NORM;
            w_ev_valid      = 1'b1;
            w_ev            = '{ext: 1'b1, rel: 1'b0, code: PS2_PAUSE_CODE};
          end
        end
        default: w_dec_state_nxt = NORM;
      endcase
    end
  end

  // Prefix decoder state register.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_dec_state <= NORM;
      r_ext       <= 1'b0;
      r_rel       <= 1'b0;
      r_skip_cnt  <= '0;
    end else begin
      r_dec_state <= w_dec_state_nxt;
      r_ext       <= w_ext_nxt;
      r_rel       <= w_rel_nxt;
      r_skip_cnt  <= w_skip_cnt_nxt;
    end
  end

  key_event_t    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic [7:0]    r_err_cnt;
  logic          w_full, w_pop, w_push;
  key_event_t    w_head;

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign w_full = (r_count == CW'(FIFO_DEPTH));
  assign w_pop  = (r_count != '0) && key_ready;
  assign w_push = w_ev_valid && (!w_full || w_pop);

  // Event FIFO storage, pointers, occupancy, overflow flag and error count.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_ev;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_ev_valid && w_full && !w_pop) r_overflow <= 1'b1;
      if (w_frame_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign w_head        = r_mem[r_rd_ptr];
  assign key_valid     = (r_count != '0);
  assign key_code      = w_head.code;
  assign key_ext       = w_head.ext;
  assign key_release   = w_head.rel;
  assign overflow      = r_overflow;
  assign err_cnt       = r_err_cnt;
  assign dbg_dec_state = r_dec_state;

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Testbench for ps2_kbd_decoder: directed scenarios plus random key streams
// compared against a byte-level reference model with an expected-event queue.
module tb_ps2_kbd_decoder;
  import ps2_pkg::*;

  localparam int FILT       = 4;
  localparam int TIMEOUT    = 4096;
  localparam int FIFO_DEPTH = 4;
  localparam int HALF       = 12;

  // ---------------- clock / reset ----------------
  logic         clk_sys   = 1'b0;
  logic         reset     = 1'b1;
  logic         ps2_clk   = 1'b1;
  logic         ps2_data  = 1'b1;
  logic         key_ready = 1'b0;
  logic         key_valid, key_ext, key_release, overflow;
  logic [7:0]   key_code, err_cnt;
  frame_state_e dbg_frame_state;
  dec_state_e   dbg_dec_state;

  always #5 clk_sys = ~clk_sys;

  ps2_kbd_decoder #(.FILT(FILT), .TIMEOUT(TIMEOUT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_sys         (clk_sys),
    .reset           (reset),
    .ps2_clk         (ps2_clk),
    .ps2_data        (ps2_data),
    .key_valid       (key_valid),
    .key_ready       (key_ready),
    .key_code        (key_code),
    .key_ext         (key_ext),
    .key_release     (key_release),
    .overflow        (overflow),
    .err_cnt         (err_cnt),
    .dbg_frame_state (dbg_frame_state),
    .dbg_dec_state   (dbg_dec_state)
  );

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_pops   = 0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_exp;
  int         exp_err  = 0;
  logic       exp_ovf  = 1'b0;
  bit         m_ext    = 1'b0;
  bit         m_rel    = 1'b0;
  int         m_skip   = 0;
  bit         rand_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (byte level) ----------------
  task automatic model_push(input bit ext, input bit rel, input logic [7:0] code);
    if (exp_q.size() < FIFO_DEPTH) exp_q.push_back({ext, rel, code});
    else                           exp_ovf = 1'b1;
  endtask

  task automatic model_err();
    exp_err = (exp_err < 255) ? exp_err + 1 : 255;
    m_ext   = 1'b0;
    m_rel   = 1'b0;
    m_skip  = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_skip > 0) begin
      m_skip--;
      if (m_skip == 0) model_push(1'b1, 1'b0, 8'h77);
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_rel = 1'b1;
    end else if (b == 8'hE1) begin
      m_skip = 7;
      m_ext  = 1'b0;
      m_rel  = 1'b0;
    end else if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) begin
      m_ext = 1'b0;
      m_rel = 1'b0;
    end else begin
      model_push(m_ext, m_rel, b);
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_err = 0;
    exp_ovf = 1'b0;
    m_ext   = 1'b0;
    m_rel   = 1'b0;
    m_skip  = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    ps2_data = b;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0, input bit bad_stop = 1'b0);
    if (bad_par || bad_stop) model_err();
    else                     model_byte(b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit((~^b) ^ bad_par);
    drive_bit(!bad_stop);
    ps2_data = 1'b1;
    wait_cyc(2 * HALF);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wait_cyc(4);
    model_reset();
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 0);
    check("rst_ext", key_ext, 0);
    check("rst_rel", key_release, 0);
    check("rst_ovf", overflow, 0);
    check("rst_err", err_cnt, 0);
    reset = 1'b0;
    wait_cyc(4);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk_sys) begin
    if (!reset && key_valid && key_ready) begin
      n_pops++;
      if (exp_q.size() == 0) begin
        check("spurious_event", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_exp = exp_q.pop_front();
        check("event", {22'd0, key_ext, key_release, key_code}, {22'd0, mon_exp});
      end
    end
  end

  // Random consumer backpressure.
  always begin
    @(posedge clk_sys);
    #1;
    if (rand_ready) key_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- stimulus ----------------
  int         p;
  int         r;
  logic [7:0] b;
  logic [7:0] discards [6];

  initial begin
    discards = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
    do_reset();
    key_ready = 1'b1;

    // Plain key.
    p = n_pops;
    send_frame(8'h1C);
    wait_cyc(10);
    check("t1_pops", n_pops - p, 1);
    check("t1_err", err_cnt, exp_err);

    // Extended release.
    p = n_pops;
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h75);
    wait_cyc(10);
    check("t2_pops", n_pops - p, 1);

    // Bad parity then good frame.
    p = n_pops;
    send_frame(8'h29, 1'b1, 1'b0);
    send_frame(8'h29);
    wait_cyc(10);
    check("t3_pops", n_pops - p, 1);
    check("t3_err", err_cnt, exp_err);

    // Partial frame stalls, then a good frame.
    p = n_pops;
    model_err();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    ps2_data = 1'b1;
    wait_cyc(TIMEOUT + 10);
    send_frame(8'h16);
    wait_cyc(10);
    check("t4_pops", n_pops - p, 1);
    check("t4_err", err_cnt, exp_err);

    // Pause make sequence.
    p = n_pops;
    send_frame(8'hE1); send_frame(8'h14); send_frame(8'h77); send_frame(8'hE1);
    send_frame(8'hF0); send_frame(8'h14); send_frame(8'hF0); send_frame(8'h77);
    wait_cyc(10);
    check("t5_pops", n_pops - p, 1);

    // Bad stop bit, and a lone fall with data high (bad start).
    send_frame(8'h1B, 1'b0, 1'b1);
    model_err();
    drive_bit(1'b1);
    wait_cyc(2 * HALF);
    check("t6_err", err_cnt, exp_err);

    // Random key stream with random consumer stalls.
    rand_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 19);
      case (r)
        0, 1, 2: b = 8'hE0;
        3, 4, 5: b = 8'hF0;
        6:       b = 8'hE1;
        7:       b = discards[$urandom_range(0, 5)];
        default: b = 8'($urandom_range(0, 255));
      endcase
      r = $urandom_range(0, 99);
      send_frame(b, r < 6, (r >= 6) && (r < 10));
    end
    rand_ready = 1'b0;
    wait_cyc(1);
    key_ready = 1'b1;
    wait_cyc(20);
    check("rand_drain", exp_q.size(), 0);
    check("rand_err", err_cnt, exp_err);
    check("rand_ovf", overflow, exp_ovf);

    // FIFO fill with consumer stalled.
    do_reset();
    key_ready = 1'b0;
    send_frame(8'h15); send_frame(8'h1D); send_frame(8'h24);
    send_frame(8'h2D); send_frame(8'h2C);
    wait_cyc(10);
    check("fill_valid", key_valid, 1);
    check("fill_ovf", overflow, exp_ovf);
    check("fill_head", key_code, exp_q[0][7:0]);
    check("fill_depth", exp_q.size(), FIFO_DEPTH);
    p = n_pops;
    key_ready = 1'b1;
    wait_cyc(20);
    check("fill_pops", n_pops - p, FIFO_DEPTH);
    check("fill_drain", exp_q.size(), 0);
    check("fill_empty", key_valid, 0);

    // Reset clears sticky overflow.
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
